rf_access_ctrl: RTL and testbench
=================================

// Module: rf_access_ctrl
// PURPOSE
//   Sequencer directly upstream of the 16x16 register file. Accepts one op at a time on a
//   valid/ready port, drives the register file's strobes for exactly one cycle, captures read
//   data and returns one response per op with rsp_valid/rsp_ready. Also owns stack-pointer
//   push/pop pairing and flag-update encoding, so the decode stage never touches raw strobes.
// PARAMETERS
//   DATA_W    16  data width of the register file
//   REG_W     4   register id width
//   SP_REG    2   id of the stack-pointer register
// PORTS
//   clk            in   1       single clock, rising edge
//   reset          in   1       asynchronous, active-low
//   req_valid      in   1       op request valid
//   req_ready      out  1       op accepted on clk edge when req_valid && req_ready
//   req_op         in   3       0 NOP,1 READ,2 WRITE,3 PUSH,4 POP,5 FLAGS,6-7 illegal
//   req_reg        in   REG_W   target register id
//   req_data       in   DATA_W  write data (WRITE/PUSH)
//   req_flag_mask  in   3       FLAGS: which flag bits to update
//   req_flags      in   3       FLAGS: new flag values
//   rsp_valid      out  1       response valid; held until rsp_ready
//   rsp_ready      in   1       consumer accepts response
//   rsp_data       out  DATA_W  read value (READ/POP), else 0
//   rsp_err        out  1       op was illegal / rejected
//   rf_rd, rf_wn   out  1       register-file read / write strobe
//   rf_stack_en    out  1       register-file stack enable
//   rf_push_en     out  1       SP increment request
//   rf_pop_en      out  1       SP decrement request
//   rf_flag_en     out  4       {update, mask[2:0]}
//   rf_flags_in    out  3       flag values to register file
//   rf_reg_id      out  REG_W   register id to register file
//   rf_write_data  out  DATA_W  write data to register file
//   rf_read_data   in   DATA_W  register-file read data (valid the cycle after rf_rd)
// BEHAVIOUR
//   - Reset (async, low): state IDLE; req_ready=1 after release; every other output 0.
//     Reset mid-op aborts it: strobes drop immediately, no response is produced.
//   - FSM: IDLE -> ISSUE -> (WAIT if READ/POP) -> RESP -> IDLE. req_ready=1 only in IDLE.
//   - All rf_* outputs are registered. They are non-zero only in ISSUE, for exactly 1 cycle.
//   - Op latched on acceptance edge E0. ISSUE = cycle after E0.
//     READ/POP: WAIT captures rf_read_data at E2; rsp_valid asserts from E2 (3rd cycle).
//     Others: rsp_valid asserts from E1.
//   - READ : rf_rd=1, rf_reg_id=req_reg.   WRITE: rf_wn=1, rf_write_data=req_data.
//   - PUSH : rf_wn=1 + rf_stack_en=1 + rf_push_en=1 in same cycle (write, then SP+1).
//   - POP  : rf_rd=1 + rf_stack_en=1 + rf_pop_en=1 in same cycle; returns pre-decrement read.
//   - FLAGS: rf_flag_en={|req_flag_mask, req_flag_mask}, rf_flags_in=req_flags.
//     A mask of 000 gives flag_en=0000; the op still responds with rsp_err=0.
//   - NOP: no strobes; response with rsp_err=0.
//   - Illegal ops are op 6/7, and PUSH/POP with req_reg==SP_REG. They pass through ISSUE with
//     all strobes 0 and respond rsp_err=1, rsp_data=0.
//   - rf_rd and rf_wn are never both 1. push_en and pop_en are never both 1.
//   - RESP: rsp_valid/data/err are stable until rsp_ready. They clear on the handshake edge,
//     which is the same edge that returns to IDLE. Back-to-back ops have a minimum period of
//     3 cycles (write) / 4 cycles (read).
//   - req_* inputs are ignored outside IDLE. rf_read_data is ignored outside WAIT.
// STRUCTURE
//   - Shared package rf_ctrl_pkg: op encodings, FSM state encoding, SP_REG, flag_en layout.
//   - One natural sub-module, rf_op_decode (combinational): latched op -> strobe set + err.
//     The FSM, output registers and response holding stay in rf_access_ctrl.
// TESTING
//   1. WRITE R5=0xBEEF, then READ R5 -> rf_wn 1 cycle with id 5; READ rsp_data=0xBEEF 3 cycles
//      after accept, rsp_err=0.
//   2. R2=0x0010; PUSH R7=0x1234 -> one cycle with wn+stack_en+push_en; READ R7=0x1234,
//      READ R2=0x0011.
//   3. POP R7 with R7=0x1234, R2=0x0011 -> rsp_data=0x1234; subsequent READ R2=0x0010.
//   4. FLAGS mask=101 flags=111 -> rf_flag_en=4'b1101; mask=000 -> rf_flag_en=0000, rsp_err=0.
//   5. op=6 and PUSH R2 -> no strobe ever high, rsp_err=1; hold rsp_ready=0 for 5 cycles
//      -> rsp stays stable, req_ready=0.
//   6. Assert reset in WAIT of a READ -> all rf_* and rsp_valid 0 at once; after release
//      req_ready=1, no stale response.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for the register-file access sequencer: op codes, FSM
// state encoding and the strobe bundle handed from decode to the output registers.
package rf_ctrl_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_WRITE = 3'd2;
    localparam logic [2:0] OP_PUSH  = 3'd3;
    localparam logic [2:0] OP_POP   = 3'd4;
    localparam logic [2:0] OP_FLAGS = 3'd5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam int SP_REG_DEFAULT = 2;

    // rf_flag_en layout: bit 3 = update, bits 2:0 = per-flag mask
    localparam int FLAG_EN_UPD_BIT = 3;

    typedef struct packed {
        logic       rd;
        logic       wn;
        logic       stack_en;
        logic       push_en;
        logic       pop_en;
        logic [3:0] flag_en;
        logic [2:0] flags_in;
    } rf_strobe_t;

    function automatic logic [3:0] flag_en_enc(input logic [2:0] mask);
        logic [3:0] w_en;
        w_en = {1'b0, mask};
        w_en[FLAG_EN_UPD_BIT] = |mask;
        return w_en;
    endfunction

endpackage

// File: rtl/rf_op_decode.sv
// Combinational decode of one request into the register-file strobe set,
// plus the illegal-op flag and whether the op returns read data.
module rf_op_decode
    import rf_ctrl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4,
    parameter int SP_REG = SP_REG_DEFAULT
) (
    input  logic [2:0]        i_op,
    input  logic [REG_W-1:0]  i_reg,
    input  logic [DATA_W-1:0] i_data,
    input  logic [2:0]        i_flag_mask,
    input  logic [2:0]        i_flags,
    output rf_strobe_t        o_strobe,
    output logic [REG_W-1:0]  o_reg_id,
    output logic [DATA_W-1:0] o_write_data,
    output logic              o_err,
    output logic              o_is_read
);

    logic w_sp_hit;

    assign w_sp_hit = (i_reg == REG_W'(SP_REG));

    always_comb begin
        o_strobe     = '0;
        o_reg_id     = '0;
        o_write_data = '0;
        o_err        = 1'b0;
        o_is_read    = 1'b0;
        case (i_op)
            OP_NOP: begin
            end
            OP_READ: begin
                o_strobe.rd = 1'b1;
                o_reg_id    = i_reg;
                o_is_read   = 1'b1;
            end
            OP_WRITE: begin
                o_strobe.wn  = 1'b1;
                o_reg_id     = i_reg;
                o_write_data = i_data;
            end
            // Stack ops may not target SP itself: the pairing would corrupt it
            OP_PUSH: begin
                if (w_sp_hit) begin
                    o_err = 1'b1;
                end else begin
                    o_strobe.wn       = 1'b1;
                    o_strobe.stack_en = 1'b1;
                    o_strobe.push_en  = 1'b1;
                    o_reg_id          = i_reg;
                    o_write_data      = i_data;
                end
            end
            OP_POP: begin
                if (w_sp_hit) begin
                    o_err = 1'b1;
                end else begin
                    o_strobe.rd       = 1'b1;
                    o_strobe.stack_en = 1'b1;
                    o_strobe.pop_en   = 1'b1;
                    o_reg_id          = i_reg;
                    o_is_read         = 1'b1;
                end
            end
            OP_FLAGS: begin
                o_strobe.flag_en  = flag_en_enc(i_flag_mask);
                o_strobe.flags_in = i_flags;
            end
            default: begin
                o_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rf_access_ctrl.sv
// Sequencer in front of the 16x16 register file: accepts one op, pulses the
// register-file strobes for one cycle, and returns one held response per op.
//
//   state | meaning
//   IDLE  | ready for a request; latches decoded strobes on accept
//   ISSUE | registered strobes visible to the register file for one cycle
//   WAIT  | read data from the register file is captured at the end of this cycle
//   RESP  | response held until rsp_ready
module rf_access_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4,
    parameter int SP_REG = SP_REG_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [REG_W-1:0]  req_reg,
    input  logic [DATA_W-1:0] req_data,
    input  logic [2:0]        req_flag_mask,
    input  logic [2:0]        req_flags,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              rf_rd,
    output logic              rf_wn,
    output logic              rf_stack_en,
    output logic              rf_push_en,
    output logic              rf_pop_en,
    output logic [3:0]        rf_flag_en,
    output logic [2:0]        rf_flags_in,
    output logic [REG_W-1:0]  rf_reg_id,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [DATA_W-1:0] rf_read_data
);

    logic [1:0]        r_state;
    rf_strobe_t        r_strobe;
    logic [REG_W-1:0]  r_reg_id;
    logic [DATA_W-1:0] r_write_data;
    logic              r_is_read;
    logic              r_err;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;

    rf_strobe_t        w_strobe;
    logic [REG_W-1:0]  w_reg_id;
    logic [DATA_W-1:0] w_write_data;
    logic              w_err;
    logic              w_is_read;

    rf_op_decode #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .SP_REG (SP_REG)
    ) u_decode (
        .i_op         (req_op),
        .i_reg        (req_reg),
        .i_data       (req_data),
        .i_flag_mask  (req_flag_mask),
        .i_flags      (req_flags),
        .o_strobe     (w_strobe),
        .o_reg_id     (w_reg_id),
        .o_write_data (w_write_data),
        .o_err        (w_err),
        .o_is_read    (w_is_read)
    );

    // Decode happens on the request itself so the strobes are registered
    // at the accept edge and appear exactly in ISSUE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_strobe     <= '0;
            r_reg_id     <= '0;
            r_write_data <= '0;
            r_is_read    <= 1'b0;
            r_err        <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_strobe     <= w_strobe;
                        r_reg_id     <= w_reg_id;
                        r_write_data <= w_write_data;
                        r_is_read    <= w_is_read;
                        r_err        <= w_err;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_strobe     <= '0;
                    r_reg_id     <= '0;
                    r_write_data <= '0;
                    if (r_is_read) begin
                        r_state <= ST_WAIT;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= r_err;
                        r_state     <= ST_RESP;
                    end
                end
                ST_WAIT: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= rf_read_data;
                    r_rsp_err   <= 1'b0;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = (r_state == ST_IDLE);
    assign rsp_valid     = r_rsp_valid;
    assign rsp_data      = r_rsp_data;
    assign rsp_err       = r_rsp_err;
    assign rf_rd         = r_strobe.rd;
    assign rf_wn         = r_strobe.wn;
    assign rf_stack_en   = r_strobe.stack_en;
    assign rf_push_en    = r_strobe.push_en;
    assign rf_pop_en     = r_strobe.pop_en;
    assign rf_flag_en    = r_strobe.flag_en;
    assign rf_flags_in   = r_strobe.flags_in;
    assign rf_reg_id     = r_reg_id;
    assign rf_write_data = r_write_data;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Bench for rf_access_ctrl: a register-file stand-in answers the strobes, and a
// per-cycle timeline model (accept cycle, response window) checks every output.
module tb_rf_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [3:0]  req_reg;
    logic [15:0] req_data;
    logic [2:0]  req_flag_mask;
    logic [2:0]  req_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        rf_rd, rf_wn, rf_stack_en, rf_push_en, rf_pop_en;
    logic [3:0]  rf_flag_en;
    logic [2:0]  rf_flags_in;
    logic [3:0]  rf_reg_id;
    logic [15:0] rf_write_data;
    logic [15:0] rf_read_data = 16'h0;

    always #5 clk = ~clk;

    rf_access_ctrl #(.DATA_W(16), .REG_W(4), .SP_REG(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_reg(req_reg),
        .req_data(req_data), .req_flag_mask(req_flag_mask), .req_flags(req_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rf_rd(rf_rd), .rf_wn(rf_wn), .rf_stack_en(rf_stack_en), .rf_push_en(rf_push_en),
        .rf_pop_en(rf_pop_en), .rf_flag_en(rf_flag_en), .rf_flags_in(rf_flags_in),
        .rf_reg_id(rf_reg_id), .rf_write_data(rf_write_data), .rf_read_data(rf_read_data)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Register-file stand-in: read data one cycle after rf_rd, junk otherwise.
    logic [15:0] env[16] = '{default: 16'h0};
    always @(posedge clk) begin
        if (rf_rd) rf_read_data <= env[rf_reg_id];
        else       rf_read_data <= 16'($urandom);
        if (rf_wn)      env[rf_reg_id] <= rf_write_data;
        if (rf_push_en) env[2] <= env[2] + 16'd1;
        if (rf_pop_en)  env[2] <= env[2] - 16'd1;
    end

    // Reference model: architectural register contents plus the current op's timeline.
    logic [15:0] mdl[16] = '{default: 16'h0};
    int          a_cyc = -1;
    int          h_cyc = 0;
    int          rsp_from = 0;
    logic        e_rd, e_wn, e_stk, e_push, e_pop;
    logic [3:0]  e_fen;
    logic [2:0]  e_fin;
    logic [3:0]  e_id;
    logic [15:0] e_wd;
    logic [15:0] e_rdata;
    logic        e_err;
    bit          chk_id, chk_wd, chk_fin;
    bit          chk_en = 0;

    logic [4:0]  cap_strb;
    logic [3:0]  cap_fen;
    logic [15:0] cap_data;
    logic        cap_err;
    int          cap_lat;
    bit          cap_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        bit busy, issue, vexp;
        if (chk_en) begin
            busy  = (a_cyc >= 0) && (cyc >= a_cyc) && (cyc < h_cyc);
            issue = busy && (cyc == a_cyc);
            vexp  = busy && (cyc >= rsp_from);
            chk("req_ready",   32'(req_ready),   32'(!busy));
            chk("rf_rd",       32'(rf_rd),       issue ? 32'(e_rd)   : 32'd0);
            chk("rf_wn",       32'(rf_wn),       issue ? 32'(e_wn)   : 32'd0);
            chk("rf_stack_en", 32'(rf_stack_en), issue ? 32'(e_stk)  : 32'd0);
            chk("rf_push_en",  32'(rf_push_en),  issue ? 32'(e_push) : 32'd0);
            chk("rf_pop_en",   32'(rf_pop_en),   issue ? 32'(e_pop)  : 32'd0);
            chk("rf_flag_en",  32'(rf_flag_en),  issue ? 32'(e_fen)  : 32'd0);
            chk("rd_wn_excl",  32'(rf_rd & rf_wn), 32'd0);
            if (!issue) begin
                chk("rf_reg_id_idle",  32'(rf_reg_id),     32'd0);
                chk("rf_wdata_idle",   32'(rf_write_data), 32'd0);
                chk("rf_flags_in_idle", 32'(rf_flags_in),  32'd0);
            end else begin
                if (chk_id)  chk("rf_reg_id",     32'(rf_reg_id),     32'(e_id));
                if (chk_wd)  chk("rf_write_data", 32'(rf_write_data), 32'(e_wd));
                if (chk_fin) chk("rf_flags_in",   32'(rf_flags_in),   32'(e_fin));
                cap_strb = {rf_rd, rf_wn, rf_stack_en, rf_push_en, rf_pop_en};
                cap_fen  = rf_flag_en;
            end
            chk("rsp_valid", 32'(rsp_valid), 32'(vexp));
            chk("rsp_data",  32'(rsp_data),  vexp ? 32'(e_rdata) : 32'd0);
            chk("rsp_err",   32'(rsp_err),   vexp ? 32'(e_err)   : 32'd0);
            if (rsp_valid && !cap_seen) begin
                cap_seen = 1;
                cap_lat  = cyc - a_cyc;
            end
            if (rsp_valid) begin
                cap_data = rsp_data;
                cap_err  = rsp_err;
            end
        end
    end

    task automatic issue_op(input logic [2:0] op, input logic [3:0] r, input logic [15:0] d,
                            input logic [2:0] m, input logic [2:0] f);
        bit rd_op;
        req_valid = 1'b1; req_op = op; req_reg = r; req_data = d;
        req_flag_mask = m; req_flags = f;
        @(posedge clk); #1;
        {e_rd, e_wn, e_stk, e_push, e_pop} = 5'b0;
        e_fen = 4'h0; e_fin = 3'h0; e_id = 4'h0; e_wd = 16'h0;
        e_rdata = 16'h0; e_err = 1'b0;
        chk_id = 0; chk_wd = 0; chk_fin = 0; rd_op = 0;
        case (op)
            3'd1: begin e_rd = 1; e_id = r; chk_id = 1; rd_op = 1; end
            3'd2: begin e_wn = 1; e_id = r; e_wd = d; chk_id = 1; chk_wd = 1; end
            3'd3: if (r == 4'd2) e_err = 1;
                  else begin e_wn = 1; e_stk = 1; e_push = 1; e_id = r; e_wd = d;
                             chk_id = 1; chk_wd = 1; end
            3'd4: if (r == 4'd2) e_err = 1;
                  else begin e_rd = 1; e_stk = 1; e_pop = 1; e_id = r; chk_id = 1; rd_op = 1; end
            3'd5: begin e_fen = {m != 3'b000, m}; e_fin = f; chk_fin = 1; end
            3'd6, 3'd7: e_err = 1;
            default: ;
        endcase
        if (rd_op) e_rdata = mdl[r];
        if (op == 3'd2) mdl[r] = d;
        if (op == 3'd3 && !e_err) begin mdl[r] = d; mdl[2] = mdl[2] + 16'd1; end
        if (op == 3'd4 && !e_err) mdl[2] = mdl[2] - 16'd1;
        a_cyc = cyc; h_cyc = 32'h7fffffff; cap_seen = 0;
        rsp_from = cyc + (rd_op ? 2 : 1);
        req_valid = 1'($urandom); req_op = 3'($urandom); req_reg = 4'($urandom);
        req_data = 16'($urandom); req_flag_mask = 3'($urandom); req_flags = 3'($urandom);
    endtask

    task automatic finish_op(input int hold);
        while (cyc < rsp_from + hold) begin @(posedge clk); #1; end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        h_cyc = cyc;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [3:0] r, input logic [15:0] d,
                         input logic [2:0] m, input logic [2:0] f, input int hold);
        issue_op(op, r, d, m, f);
        finish_op(hold);
    endtask

    task automatic reset_mid(input logic [2:0] op, input logic [3:0] r, input logic [15:0] d,
                             input int off);
        logic [15:0] snap[16];
        snap = mdl;
        issue_op(op, r, d, 3'b0, 3'b0);
        while (cyc < a_cyc + off) begin @(posedge clk); #1; end
        chk_en = 0;
        reset = 1'b0;
        #1;
        chk("rst_rf_all", {rf_rd, rf_wn, rf_stack_en, rf_push_en, rf_pop_en, rf_flag_en,
                           rf_flags_in, rf_reg_id, rf_write_data}, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data",  32'(rsp_data),  32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        if (off == 0) mdl = snap;
        repeat (2) @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; rsp_ready = 1'b0; a_cyc = -1;
        reset = 1'b1;
        chk_en = 1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = 3'd0; req_reg = 4'd0; req_data = 16'd0; req_flag_mask = 3'd0; req_flags = 3'd0;
        #2;
        chk("reset_rf_all", {rf_rd, rf_wn, rf_stack_en, rf_push_en, rf_pop_en, rf_flag_en,
                             rf_flags_in, rf_reg_id, rf_write_data}, 32'd0);
        chk("reset_rsp", {rsp_valid, rsp_err, rsp_data}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk_en = 1;
        @(negedge clk);

        // 1: write then read back, read latency 2 cycles past accept
        do_op(3'd2, 4'd5, 16'hBEEF, 3'd0, 3'd0, 0);
        chk("t1_write_lat", 32'(cap_lat), 32'd1);
        chk("t1_write_strb", 32'(cap_strb), 32'b01000);
        do_op(3'd1, 4'd5, 16'h0, 3'd0, 3'd0, 0);
        chk("t1_read_data", 32'(cap_data), 32'hBEEF);
        chk("t1_read_lat", 32'(cap_lat), 32'd2);
        chk("t1_read_err", 32'(cap_err), 32'd0);

        // 2: push pairs write with SP increment
        do_op(3'd2, 4'd2, 16'h0010, 3'd0, 3'd0, 1);
        do_op(3'd3, 4'd7, 16'h1234, 3'd0, 3'd0, 0);
        chk("t2_push_strb", 32'(cap_strb), 32'b01110);
        do_op(3'd1, 4'd7, 16'h0, 3'd0, 3'd0, 0);
        chk("t2_r7", 32'(cap_data), 32'h1234);
        do_op(3'd1, 4'd2, 16'h0, 3'd0, 3'd0, 2);
        chk("t2_sp", 32'(cap_data), 32'h0011);

        // 3: pop returns pre-decrement value
        do_op(3'd4, 4'd7, 16'h0, 3'd0, 3'd0, 0);
        chk("t3_pop_data", 32'(cap_data), 32'h1234);
        chk("t3_pop_strb", 32'(cap_strb), 32'b10101);
        do_op(3'd1, 4'd2, 16'h0, 3'd0, 3'd0, 0);
        chk("t3_sp", 32'(cap_data), 32'h0010);

        // 4: flag encoding
        do_op(3'd5, 4'd0, 16'h0, 3'b101, 3'b111, 0);
        chk("t4_fen_101", 32'(cap_fen), 32'b1101);
        do_op(3'd5, 4'd0, 16'h0, 3'b000, 3'b111, 0);
        chk("t4_fen_000", 32'(cap_fen), 32'b0000);
        chk("t4_err", 32'(cap_err), 32'd0);

        // 5: illegal ops, response held while consumer stalls
        do_op(3'd6, 4'd3, 16'hAAAA, 3'd7, 3'd7, 5);
        chk("t5_op6_err", 32'(cap_err), 32'd1);
        chk("t5_op6_strb", 32'(cap_strb), 32'd0);
        do_op(3'd3, 4'd2, 16'h5555, 3'd0, 3'd0, 5);
        chk("t5_push_sp_err", 32'(cap_err), 32'd1);
        chk("t5_push_sp_data", 32'(cap_data), 32'd0);

        // 6: reset in WAIT of a read, in ISSUE of a write, in RESP of a write
        reset_mid(3'd1, 4'd5, 16'h0, 1);
        reset_mid(3'd2, 4'd9, 16'h7777, 0);
        reset_mid(3'd2, 4'd9, 16'h3333, 2);
        do_op(3'd1, 4'd9, 16'h0, 3'd0, 3'd0, 0);
        chk("t6_r9", 32'(cap_data), 32'h3333);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r;
            r = ($urandom_range(0, 3) == 0) ? 4'd2 : 4'($urandom_range(0, 15));
            do_op(3'($urandom_range(0, 7)), r, 16'($urandom), 3'($urandom), 3'($urandom),
                  int'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
        end

        // Architectural state of the stand-in must match the model
        for (int k = 0; k < 16; k++) chk("final_reg", 32'(env[k]), 32'(mdl[k]));

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
